// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - operation encodings carried on E_MDOp
//   - op class enum and decode helpers (op_class, is_multicycle, is_signed_op)
// Optional feature macro: MDU_MADD_EN decodes MADD/MADDU/MSUB/MSUBU as
// multiply-class ops. Without it, codes 7-10 decode as NONE.
package mdu_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_MUL,
    CLS_DIV,
    CLS_MOVE
  } op_class_e;

  function automatic op_class_e op_class(input logic [3:0] op);
    case (op)
      OP_MULT, OP_MULTU: return CLS_MUL;
      OP_DIV,  OP_DIVU:  return CLS_DIV;
      OP_MTHI, OP_MTLO:  return CLS_MOVE;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return CLS_MUL;
`endif
      default:           return CLS_NONE;
    endcase
  endfunction

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op_class(op) == CLS_MUL) || (op_class(op) == CLS_DIV);
  endfunction

  // Signedness of the operands; unsigned variants fall through to 0.
  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if: E-stage handshake between the pipeline and the multiply/divide unit.
//   master (pipeline): drives E_Start, E_MDOp, E_A, E_B; observes results.
//   slave  (mdu):      drives E_HI, E_LO, E_Busy, E_MDStall.
interface mdu_if #(parameter int WIDTH = 32);
  logic             E_Start;
  logic [3:0]       E_MDOp;
  logic [WIDTH-1:0] E_A;
  logic [WIDTH-1:0] E_B;
  logic [WIDTH-1:0] E_HI;
  logic [WIDTH-1:0] E_LO;
  logic             E_Busy;
  logic             E_MDStall;

  modport master (
    output E_Start, E_MDOp, E_A, E_B,
    input  E_HI, E_LO, E_Busy, E_MDStall
  );

  modport slave (
    input  E_Start, E_MDOp, E_A, E_B,
    output E_HI, E_LO, E_Busy, E_MDStall
  );
endinterface

// File: rtl/mdu_calc.sv
// mdu_calc: combinational arithmetic core of the multiply/divide unit.
//   a, b      : operands
//   is_signed : treat operands as two's complement
//   prod      : 2*WIDTH-bit product
//   quot, rem : truncating quotient/remainder (remainder takes dividend sign)
//   div_zero  : divisor is zero (quot/rem are don't-care)
module mdu_calc #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic [2*WIDTH-1:0] prod,
  output logic [WIDTH-1:0]   quot,
  output logic [WIDTH-1:0]   rem,
  output logic               div_zero
);

  logic [2*WIDTH-1:0] a_ext, b_ext;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, b_safe, q_mag, r_mag;

  always_comb begin
    // Sign- or zero-extend to 2*WIDTH; the truncated product is then exact
    // for both signed and unsigned operands.
    a_ext = {{WIDTH{is_signed & a[WIDTH-1]}}, a};
    b_ext = {{WIDTH{is_signed & b[WIDTH-1]}}, b};
    prod  = a_ext * b_ext;

    // Divide on magnitudes. |min| as unsigned is 2^(WIDTH-1), so min / -1
    // wraps back to min with remainder 0, never hitting signed overflow.
    a_neg    = is_signed & a[WIDTH-1];
    b_neg    = is_signed & b[WIDTH-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    div_zero = (b == '0);
    b_safe   = div_zero ? WIDTH'(1) : b_mag;
    q_mag    = a_mag / b_safe;
    r_mag    = a_mag % b_safe;
    quot     = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem      = a_neg ? -r_mag : r_mag;
  end

endmodule

// File: rtl/mdu.sv
// mdu: multiply/divide unit with HI/LO register pair for the E stage.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   bus        : mdu_if.slave (E_Start/E_MDOp/E_A/E_B in; E_HI/E_LO/E_Busy/E_MDStall out)
// Accepted multiply ops hold E_Busy for MULT_CYCLES, divides for DIV_CYCLES;
// HI/LO commit on the edge where E_Busy falls. MTHI/MTLO write immediately.
// Optional feature macro: MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU, which
// accumulate into the HI/LO value present at completion.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]         state_q,   state_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [WIDTH-1:0]   hi_q,      hi_d;
  logic [WIDTH-1:0]   lo_q,      lo_d;
  logic [2*WIDTH-1:0] pend_q,    pend_d;
  logic [3:0]         pend_op_q, pend_op_d;
  logic               pend_dz_q, pend_dz_d;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem;
  logic               div_zero;
  logic [2*WIDTH-1:0] acc;
  op_class_e          cls;

  mdu_calc #(.WIDTH(WIDTH)) u_calc (
    .a         (bus.E_A),
    .b         (bus.E_B),
    .is_signed (is_signed_op(bus.E_MDOp)),
    .prod      (prod),
    .quot      (quot),
    .rem       (rem),
    .div_zero  (div_zero)
  );

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_d    = pend_q;
    pend_op_d = pend_op_q;
    pend_dz_d = pend_dz_q;
    acc       = {hi_q, lo_q};
    cls       = op_class(bus.E_MDOp);

    if (state_q == ST_IDLE) begin
      // Idle is the only state that accepts; E_Start while busy is dropped.
      if (bus.E_Start) begin
        case (cls)
          CLS_MOVE: begin
            if (bus.E_MDOp == OP_MTHI) hi_d = bus.E_A;
            else                       lo_d = bus.E_A;
          end
          CLS_MUL, CLS_DIV: begin
            state_d   = ST_BUSY;
            pend_op_d = bus.E_MDOp;
            cnt_d     = (cls == CLS_DIV) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            pend_d    = (cls == CLS_DIV) ? {rem, quot} : prod;
            pend_dz_d = (cls == CLS_DIV) && div_zero;
          end
          default: ;
        endcase
      end
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        state_d   = ST_IDLE;
        pend_d    = '0;
        pend_op_d = OP_NONE;
        pend_dz_d = 1'b0;
        case (pend_op_q)
`ifdef MDU_MADD_EN
          OP_MADD, OP_MADDU: acc = {hi_q, lo_q} + pend_q;
          OP_MSUB, OP_MSUBU: acc = {hi_q, lo_q} - pend_q;
`endif
          default:           acc = pend_q;
        endcase
        // A divide by zero still spends its latency but leaves HI/LO alone.
        if (!pend_dz_q) {hi_d, lo_d} = acc;
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_q    <= '0;
      pend_op_q <= OP_NONE;
      pend_dz_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_q    <= pend_d;
      pend_op_q <= pend_op_d;
      pend_dz_q <= pend_dz_d;
    end
  end

  assign bus.E_HI      = hi_q;
  assign bus.E_LO      = lo_q;
  assign bus.E_Busy    = (state_q == ST_BUSY);
  // Combinational from E_Start so dependent D-stage ops stall in the accept cycle.
  assign bus.E_MDStall = bus.E_Busy | (bus.E_Start & is_multicycle(bus.E_MDOp));

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed self-checking bench for mdu (WIDTH=32, MULT=5, DIV=10).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mdu;
  import mdu_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_busy;

  mdu_if #(.WIDTH(32)) bus ();

  mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Present one op for one cycle; returns at the falling edge after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic exp_stall, input string tag);
    @(negedge clk);
    bus.E_Start = 1'b1;
    bus.E_MDOp  = op;
    bus.E_A     = a;
    bus.E_B     = b;
    #1 check({tag, "_stall"}, 64'(bus.E_MDStall), 64'(exp_stall));
    @(negedge clk);
    bus.E_Start = 1'b0;
  endtask

  // Count falling edges with E_Busy high, bounded so a stuck unit still ends.
  task automatic wait_idle(output int n);
    n = 0;
    while (bus.E_Busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.E_Start = 1'b0;
    bus.E_MDOp  = OP_NONE;
    bus.E_A     = '0;
    bus.E_B     = '0;
    repeat (2) @(negedge clk);
    check("rst_hi",    64'(bus.E_HI), 64'h0);
    check("rst_lo",    64'(bus.E_LO), 64'h0);
    check("rst_busy",  64'(bus.E_Busy), 64'h0);
    check("rst_stall", 64'(bus.E_MDStall), 64'h0);
    reset = 1'b0;

    // MULT -1 * 2 = -2 -> HI=FFFFFFFF LO=FFFFFFFE
    issue(OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b1, "mult");
    check("mult_busy_stall", 64'(bus.E_MDStall), 64'h1);
    wait_idle(n_busy);
    check("mult_cycles", 64'(n_busy), 64'd5);
    check("mult_hi", 64'(bus.E_HI), 64'hFFFF_FFFF);
    check("mult_lo", 64'(bus.E_LO), 64'hFFFF_FFFE);

    issue(OP_DIVU, 32'd17, 32'd5, 1'b1, "divu");
    wait_idle(n_busy);
    check("divu_cycles", 64'(n_busy), 64'd10);
    check("divu_lo", 64'(bus.E_LO), 64'd3);
    check("divu_hi", 64'(bus.E_HI), 64'd2);

    issue(OP_DIV, 32'hFFFF_FFEF, 32'd5, 1'b1, "div_neg");
    wait_idle(n_busy);
    check("div_neg_lo", 64'(bus.E_LO), 64'hFFFF_FFFD);
    check("div_neg_hi", 64'(bus.E_HI), 64'hFFFF_FFFE);

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_ovf");
    wait_idle(n_busy);
    check("div_ovf_lo", 64'(bus.E_LO), 64'h8000_0000);
    check("div_ovf_hi", 64'(bus.E_HI), 64'h0);

    // MTHI then MTLO back to back: no busy, visible the cycle after each edge.
    @(negedge clk);
    bus.E_Start = 1'b1;
    bus.E_MDOp  = OP_MTHI;
    bus.E_A     = 32'h1234;
    #1 check("mthi_stall", 64'(bus.E_MDStall), 64'h0);
    @(negedge clk);
    check("mthi_busy", 64'(bus.E_Busy), 64'h0);
    check("mthi_hi",   64'(bus.E_HI), 64'h1234);
    bus.E_MDOp = OP_MTLO;
    bus.E_A    = 32'h5678;
    @(negedge clk);
    bus.E_Start = 1'b0;
    check("mtlo_busy", 64'(bus.E_Busy), 64'h0);
    check("mtlo_lo",   64'(bus.E_LO), 64'h5678);
    check("mtlo_hi",   64'(bus.E_HI), 64'h1234);

    issue(OP_DIV, 32'd99, 32'd0, 1'b1, "div0");
    wait_idle(n_busy);
    check("div0_cycles", 64'(n_busy), 64'd10);
    check("div0_hi", 64'(bus.E_HI), 64'h1234);
    check("div0_lo", 64'(bus.E_LO), 64'h5678);

    // Start pulse while busy must be ignored; one busy cycle passes during it.
    issue(OP_MULTU, 32'h10, 32'h10, 1'b1, "multu");
    bus.E_Start = 1'b1;
    bus.E_MDOp  = OP_MTHI;
    bus.E_A     = 32'hDEAD;
    @(negedge clk);
    bus.E_Start = 1'b0;
    check("ign_hi_mid", 64'(bus.E_HI), 64'h1234);
    wait_idle(n_busy);
    check("ign_cycles", 64'(n_busy), 64'd4);
    check("ign_hi", 64'(bus.E_HI), 64'h0);
    check("ign_lo", 64'(bus.E_LO), 64'h100);

`ifdef MDU_MADD_EN
    issue(OP_MTHI, 32'd0, 32'd0, 1'b0, "acc_mthi");
    issue(OP_MTLO, 32'd1, 32'd0, 1'b0, "acc_mtlo");
    issue(OP_MADD, 32'd3, 32'd4, 1'b1, "madd");
    wait_idle(n_busy);
    check("madd_cycles", 64'(n_busy), 64'd5);
    check("madd_hi", 64'(bus.E_HI), 64'h0);
    check("madd_lo", 64'(bus.E_LO), 64'd13);
    issue(OP_MSUBU, 32'd1, 32'd14, 1'b1, "msubu");
    wait_idle(n_busy);
    check("msubu_hi", 64'(bus.E_HI), 64'hFFFF_FFFF);
    check("msubu_lo", 64'(bus.E_LO), 64'hFFFF_FFFF);
`else
    issue(4'd7, 32'd5, 32'd5, 1'b0, "op7");
    check("op7_busy", 64'(bus.E_Busy), 64'h0);
    check("op7_hi", 64'(bus.E_HI), 64'h0);
    check("op7_lo", 64'(bus.E_LO), 64'h100);
`endif

    // Reset during busy cycle 3 of a MULT: immediate clear, no late commit.
    issue(OP_MULT, 32'd3, 32'd3, 1'b1, "mult_rst");
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_busy_before", 64'(bus.E_Busy), 64'h1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_busy", 64'(bus.E_Busy), 64'h0);
    check("rst_mid_hi",   64'(bus.E_HI), 64'h0);
    check("rst_mid_lo",   64'(bus.E_LO), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_after_busy", 64'(bus.E_Busy), 64'h0);
    check("rst_after_hi",   64'(bus.E_HI), 64'h0);
    check("rst_after_lo",   64'(bus.E_LO), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
